komut_yukleyici: RTL and testbench
==================================

# komut_yukleyici

Instruction loader and instruction memory that sits directly upstream of the single-cycle processor. A byte-serial stream fills an on-chip instruction RAM while the block holds the processor in reset. Once loading completes, the block releases the processor and serves `komut_islemci` combinationally from the processor's `pc_islemci`. It halts the processor again on a processor error or an illegal fetch.

## Interface
Parameters:
- `DERINLIK`, default 256: instruction RAM depth in 32-bit words; power of two, 2..65536.
- `ADRES_BIT`, default 8: log2(`DERINLIK`).

Ports:
- `clk` in 1: the single clock; all state changes on its rising edge.
- `reset` in 1: synchronous, active-high.
- `yukle_gecerli` in 1: load byte valid.
- `yukle_bayt` in 8: load byte.
- `yukle_hazir` out 1: loader ready; a byte transfers on an edge where `yukle_gecerli`=1 and `yukle_hazir`=1.
- `pc_islemci` in 32: fetch address from the processor.
- `komut_islemci` out 32: instruction to the processor (combinational).
- `islemci_reset` out 1: registered reset to the processor.
- `hata_islemci` in 1: processor error flag.
- `durum` out 2: state, encoded 00 SAYI_AL, 01 YUKLE, 10 CALIS, 11 DUR.
- `yukle_hata` out 1: sticky flag, set on an illegal word count.
- `hata_bellek` out 1: combinational illegal-fetch flag.

## Operation
- Stream format:
  - 2 bytes: word count N, 16-bit little-endian.
  - Then 4N bytes: the words, each little-endian (first byte is [7:0]), written to word addresses 0..N-1 in order.
- **SAYI_AL**
  - `yukle_hazir`=1.
  - 1st accepted byte goes to N[7:0]; 2nd goes to N[15:8].
  - On the edge accepting the 2nd byte:
    - N=0 or N>`DERINLIK`: go to DUR and set `yukle_hata`.
    - Otherwise: go to YUKLE; `kelime_sayaci`=0, `bayt_sayaci`=0.
- **YUKLE**
  - `yukle_hazir`=1.
  - Each accepted byte shifts into the 32-bit assembly register; `bayt_sayaci` increments mod 4.
  - On the 4th byte, the assembled word (including that byte) is written to RAM[`kelime_sayaci`] on the same edge, and `kelime_sayaci` increments.
  - When the written word is index N-1, go to CALIS on that edge.
- **CALIS**
  - `yukle_hazir`=0; incoming bytes are ignored.
  - Word index: w = `pc_islemci`[ADRES_BIT+1:2].
  - `hata_bellek`=1 if `pc_islemci`[1:0]≠0, or w≥N, or `pc_islemci`[31:ADRES_BIT+2]≠0.
  - `komut_islemci` = RAM[w] if `hata_bellek`=0, else 32'h00000013 (NOP).
  - If `hata_islemci`=1 or `hata_bellek`=1 at an edge, go to DUR.
- **DUR**
  - `yukle_hazir`=0, `komut_islemci`=NOP, `hata_bellek`=0.
  - Left only by `reset`.
- Outside CALIS, `komut_islemci`=NOP and `hata_bellek`=0.
- `islemci_reset` is a register: 1 in SAYI_AL, YUKLE and DUR; 0 in CALIS. It follows the state register with no extra delay.
- RAM contents are not reset. Words at index ≥N are never driven to the processor.
- N is held in a 17-bit comparison so that N=`DERINLIK` is legal.

## Timing
- Reset values:
  - state SAYI_AL, `durum`=00.
  - `yukle_hazir`=1, `islemci_reset`=1, `yukle_hata`=0.
  - N=0 and all counters 0.
  - `komut_islemci`=NOP, `hata_bellek`=0.
- Assertion of `reset` in any state, including mid-word in YUKLE, restores the reset values at that edge. A partially assembled word is discarded. Words already written stay in RAM but are unreachable until reloaded.
- Byte transfer: zero-latency handshake. `yukle_gecerli` gaps of any length leave all counters unchanged.
- Load completion: let edge k accept the final byte. At edge k the RAM write, state→CALIS, `islemci_reset`→0 and `yukle_hazir`→0 all occur. From cycle k+1 the processor runs with pc=0, and `komut_islemci`=RAM[0] in that same cycle.
- Read path: `komut_islemci` and `hata_bellek` are combinational from `pc_islemci` and state, with no cycle latency (single-cycle processor).
- Halt:
  - `hata_islemci`=1 or `hata_bellek`=1 sampled at edge h in CALIS: state=DUR and `islemci_reset`=1 from cycle h+1.
  - The processor's own writes at edge h are not suppressed.
- Simultaneous events:
  - `reset` dominates all other inputs.
  - In CALIS, `hata_islemci` and `hata_bellek` together produce a single DUR transition.

## Test plan
- Load N=3, words 0x00500093, 0x00A00113, 0x002081B3 (14 bytes, no gaps):
  - `durum` goes 00→01→10.
  - `islemci_reset` falls on the edge of byte 14.
  - With pc=0/4/8, `komut_islemci` shows the three words in order.
- Same load with `yukle_gecerli` low for 3 cycles between every byte → identical RAM contents. Counters are frozen during the gaps, and the CALIS entry edge coincides with the 14th accepted byte.
- Count N=0, then separately N=`DERINLIK`+1 → DUR at the 2nd byte, `yukle_hata`=1, `yukle_hazir`=0, `islemci_reset` stays 1. N=`DERINLIK` is accepted.
- In CALIS with N=3, drive pc=0x6 (misaligned), then pc=0xC (w=3≥N) → `hata_bellek`=1 and `komut_islemci`=0x00000013 in the same cycle, then DUR and `islemci_reset`=1 on the next edge.
- In CALIS, pulse `hata_islemci` for 1 cycle → DUR on the next edge, `komut_islemci`=NOP thereafter. A following `reset` returns the block to SAYI_AL with all reset values.
- Assert `reset` after 6 bytes of a load, then perform a full N=1 load of 0xDEADBEEF → RAM[0]=0xDEADBEEF, N=1, and pc=4 flags `hata_bellek`.

Source files
------------

// File: rtl/komut_yukleyici_if.sv
// rtl/komut_yukleyici_if.sv - byte-serial load stream into the instruction loader
// Source side drives valid/byte, the loader answers with ready.
interface komut_yukleyici_if;
  logic       yukle_gecerli;
  logic [7:0] yukle_bayt;
  logic       yukle_hazir;

  modport master (output yukle_gecerli, output yukle_bayt, input yukle_hazir);
  modport slave  (input yukle_gecerli, input yukle_bayt, output yukle_hazir);
endinterface

// File: rtl/komut_yukleyici.sv
// rtl/komut_yukleyici.sv - instruction loader and instruction RAM for the single-cycle core
// Fills RAM from a counted byte stream, then serves fetches combinationally until halted.
module komut_yukleyici #(
  parameter int DERINLIK  = 256,
  parameter int ADRES_BIT = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  komut_yukleyici_if.slave          yukle,
  input  logic [31:0]               pc_islemci,
  output logic [31:0]               komut_islemci,
  output logic                      islemci_reset,
  input  logic                      hata_islemci,
  output logic [1:0]                durum,
  output logic                      yukle_hata,
  output logic                      hata_bellek
);

  typedef enum logic [1:0] {
    SAYI_AL = 2'b00,
    YUKLE   = 2'b01,
    CALIS   = 2'b10,
    DUR     = 2'b11
  } durum_t;

  localparam logic [31:0] NOP         = 32'h0000_0013;
  localparam logic [16:0] DERINLIK_17 = 17'(DERINLIK);

  durum_t                 state_q, state_d;
  logic [16:0]            n_q, n_d;
  logic [ADRES_BIT-1:0]   kelime_q, kelime_d;
  logic [1:0]             bayt_q, bayt_d;
  logic [31:0]            word_q, word_d;
  logic                   yukle_hata_q, yukle_hata_d;
  logic                   islemci_reset_q, islemci_reset_d;
  logic [31:0]            ram_q [DERINLIK];

  logic                   kabul;
  logic                   ram_we;
  logic [31:0]            yeni_kelime;
  logic [ADRES_BIT-1:0]   w;

  assign yukle.yukle_hazir = (state_q == SAYI_AL) || (state_q == YUKLE);
  assign kabul             = yukle.yukle_gecerli && yukle.yukle_hazir;
  // Little-endian assembly: the first byte ends up in [7:0] after four shifts.
  assign yeni_kelime       = {yukle.yukle_bayt, word_q[31:8]};
  assign w                 = pc_islemci[ADRES_BIT+1:2];

  always_comb begin
    state_d      = state_q;
    n_d          = n_q;
    kelime_d     = kelime_q;
    bayt_d       = bayt_q;
    word_d       = word_q;
    yukle_hata_d = yukle_hata_q;
    ram_we       = 1'b0;
    case (state_q)
      SAYI_AL: begin
        if (kabul) begin
          if (bayt_q == 2'd0) begin
            n_d    = {9'd0, yukle.yukle_bayt};
            bayt_d = 2'd1;
          end else begin
            n_d      = {1'b0, yukle.yukle_bayt, n_q[7:0]};
            bayt_d   = 2'd0;
            kelime_d = '0;
            if (n_d == 17'd0 || n_d > DERINLIK_17) begin
              state_d      = DUR;
              yukle_hata_d = 1'b1;
            end else begin
              state_d = YUKLE;
            end
          end
        end
      end
      YUKLE: begin
        if (kabul) begin
          word_d = yeni_kelime;
          bayt_d = bayt_q + 2'd1;
          if (bayt_q == 2'd3) begin
            ram_we   = 1'b1;
            kelime_d = kelime_q + 1'b1;
            if (17'(kelime_q) + 17'd1 == n_q) state_d = CALIS;
          end
        end
      end
      CALIS: begin
        if (hata_islemci || hata_bellek) state_d = DUR;
      end
      default: state_d = DUR;
    endcase
    islemci_reset_d = (state_d != CALIS);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= SAYI_AL;
      n_q             <= '0;
      kelime_q        <= '0;
      bayt_q          <= '0;
      word_q          <= '0;
      yukle_hata_q    <= 1'b0;
      islemci_reset_q <= 1'b1;
    end else begin
      state_q         <= state_d;
      n_q             <= n_d;
      kelime_q        <= kelime_d;
      bayt_q          <= bayt_d;
      word_q          <= word_d;
      yukle_hata_q    <= yukle_hata_d;
      islemci_reset_q <= islemci_reset_d;
    end
  end

  always_ff @(posedge clk) begin
    if (ram_we && !reset) ram_q[kelime_q] <= yeni_kelime;
  end

  // Fetch path is purely combinational; words at index >= N are never exposed.
  always_comb begin
    hata_bellek   = 1'b0;
    komut_islemci = NOP;
    if (state_q == CALIS) begin
      hata_bellek = (pc_islemci[1:0] != 2'b00) || (17'(w) >= n_q) ||
                    (pc_islemci[31:ADRES_BIT+2] != '0);
      if (!hata_bellek) komut_islemci = ram_q[w];
    end
  end

  assign durum         = state_q;
  assign yukle_hata    = yukle_hata_q;
  assign islemci_reset = islemci_reset_q;

endmodule

// File: tb/tb_komut_yukleyici.sv
// tb/tb_komut_yukleyici.sv - self-checking bench for komut_yukleyici
// Reference model: expected RAM image, word count and per-byte state from stream rules.
module tb_komut_yukleyici;
  localparam int          DERINLIK  = 256;
  localparam int          ADRES_BIT = 8;
  localparam logic [31:0] NOP       = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc_islemci;
  logic [31:0] komut_islemci;
  logic        islemci_reset;
  logic        hata_islemci;
  logic [1:0]  durum;
  logic        yukle_hata;
  logic        hata_bellek;

  komut_yukleyici_if yif();

  komut_yukleyici #(.DERINLIK(DERINLIK), .ADRES_BIT(ADRES_BIT)) dut (
    .clk           (clk),
    .reset         (reset),
    .yukle         (yif.slave),
    .pc_islemci    (pc_islemci),
    .komut_islemci (komut_islemci),
    .islemci_reset (islemci_reset),
    .hata_islemci  (hata_islemci),
    .durum         (durum),
    .yukle_hata    (yukle_hata),
    .hata_bellek   (hata_bellek)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] mem_m [DERINLIK];
  int          n_m = 0;
  logic [31:0] temel [$] = '{32'h0050_0093, 32'h00A0_0113, 32'h0020_81B3};

  // Expected state after k accepted bytes of a stream announcing n words.
  function automatic logic [1:0] exp_durum(int k, int n);
    bit legal = (n >= 1) && (n <= DERINLIK);
    if (k < 2) return 2'b00;
    if (!legal) return 2'b11;
    if (k == 2 + 4 * n) return 2'b10;
    return 2'b01;
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    yif.yukle_gecerli = 1'b0;
    yif.yukle_bayt = 8'h00;
    hata_islemci = 1'b0;
    pc_islemci = 32'h0;
    @(posedge clk); #1;
    reset = 1'b0;
    n_m = 0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    yif.yukle_gecerli = 1'b1;
    yif.yukle_bayt = b;
    @(posedge clk); #1;
    yif.yukle_gecerli = 1'b0;
    yif.yukle_bayt = 8'($urandom);
  endtask

  task automatic load(input int n, input logic [31:0] w[$], input int gmin, input int gmax);
    logic [7:0] q[$];
    logic [1:0] e;
    int total;
    q.push_back(n[7:0]);
    q.push_back(n[15:8]);
    for (int i = 0; i < w.size(); i++)
      for (int b = 0; b < 4; b++) q.push_back(w[i][8*b +: 8]);
    total = (n >= 1 && n <= DERINLIK) ? 2 + 4 * n : 2;
    for (int k = 1; k <= total; k++) begin
      int gap = $urandom_range(gmax, gmin);
      if (gap > 0) begin
        repeat (gap) begin
          yif.yukle_bayt = 8'($urandom);
          @(posedge clk); #1;
        end
        e = exp_durum(k - 1, n);
        checks++;
        if (durum !== e) begin
          errors++;
          $display("FAIL gap_durum byte=%0d got=%0d want=%0d", k, durum, e);
        end
      end
      send_byte(q[k-1]);
      e = exp_durum(k, n);
      checks++;
      if (durum !== e || yif.yukle_hazir !== (e < 2'b10) || islemci_reset !== (e != 2'b10)) begin
        errors++;
        $display("FAIL load_step byte=%0d durum=%0d hazir=%0b rst=%0b want durum=%0d", k, durum,
                 yif.yukle_hazir, islemci_reset, e);
      end
    end
    if (n >= 1 && n <= DERINLIK) begin
      n_m = n;
      for (int i = 0; i < n; i++) mem_m[i] = w[i];
    end
  endtask

  task automatic peek(input logic [31:0] a);
    logic        eh;
    logic [31:0] ek;
    @(negedge clk);
    pc_islemci = a;
    #1;
    eh = (a[1:0] != 2'b00) || ((a >> 2) >= 32'(n_m));
    ek = eh ? NOP : mem_m[a >> 2];
    checks++;
    if (komut_islemci !== ek || hata_bellek !== eh) begin
      errors++;
      $display("FAIL fetch pc=%h komut=%h hata=%0b want komut=%h hata=%0b", a, komut_islemci,
               hata_bellek, ek, eh);
    end
    pc_islemci = 32'h0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (durum !== 2'b00 || yif.yukle_hazir !== 1'b1 || islemci_reset !== 1'b1 ||
        yukle_hata !== 1'b0 || komut_islemci !== NOP || hata_bellek !== 1'b0) begin
      errors++;
      $display("FAIL reset durum=%0d hazir=%0b rst=%0b yh=%0b komut=%h hb=%0b", durum,
               yif.yukle_hazir, islemci_reset, yukle_hata, komut_islemci, hata_bellek);
    end
  endtask

  task automatic test_basic_load();
    do_reset();
    load(3, temel, 0, 0);
    checks++;
    if (komut_islemci !== 32'h0050_0093) begin
      errors++;
      $display("FAIL first_fetch got=%h want=%h", komut_islemci, 32'h0050_0093);
    end
    peek(32'h0); peek(32'h4); peek(32'h8);
  endtask

  task automatic test_gaps();
    do_reset();
    load(3, temel, 3, 3);
    peek(32'h0); peek(32'h4); peek(32'h8); peek(32'hC);
  endtask

  task automatic test_bad_count();
    logic [31:0] w[$];
    int bad[2] = '{0, DERINLIK + 1};
    foreach (bad[i]) begin
      do_reset();
      load(bad[i], w, 0, 0);
      send_byte(8'hAA);
      checks++;
      if (durum !== 2'b11 || yukle_hata !== 1'b1 || yif.yukle_hazir !== 1'b0 ||
          islemci_reset !== 1'b1) begin
        errors++;
        $display("FAIL bad_count n=%0d durum=%0d yh=%0b hazir=%0b rst=%0b", bad[i], durum,
                 yukle_hata, yif.yukle_hazir, islemci_reset);
      end
    end
    do_reset();
    for (int i = 0; i < DERINLIK; i++) w.push_back($urandom);
    load(DERINLIK, w, 0, 0);
    checks++;
    if (yukle_hata !== 1'b0) begin
      errors++;
      $display("FAIL full_count yukle_hata=%0b want=0", yukle_hata);
    end
    peek(32'h0); peek(32'(4 * (DERINLIK - 1))); peek(32'(4 * DERINLIK)); peek(32'h8000_0000);
  endtask

  task automatic test_fetch_halt();
    logic [31:0] bad_pc[2] = '{32'h6, 32'hC};
    foreach (bad_pc[i]) begin
      do_reset();
      load(3, temel, 0, 0);
      @(negedge clk);
      pc_islemci = bad_pc[i];
      #1;
      checks++;
      if (hata_bellek !== 1'b1 || komut_islemci !== NOP) begin
        errors++;
        $display("FAIL bad_fetch pc=%h hb=%0b komut=%h want hb=1 komut=%h", bad_pc[i],
                 hata_bellek, komut_islemci, NOP);
      end
      @(posedge clk); #1;
      pc_islemci = 32'h0;
      #1;
      checks++;
      if (durum !== 2'b11 || islemci_reset !== 1'b1 || hata_bellek !== 1'b0 ||
          komut_islemci !== NOP) begin
        errors++;
        $display("FAIL fetch_halt durum=%0d rst=%0b hb=%0b komut=%h", durum, islemci_reset,
                 hata_bellek, komut_islemci);
      end
    end
  endtask

  task automatic test_hata_islemci();
    do_reset();
    load(3, temel, 0, 0);
    @(negedge clk);
    hata_islemci = 1'b1;
    @(posedge clk); #1;
    hata_islemci = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (durum !== 2'b11 || islemci_reset !== 1'b1 || komut_islemci !== NOP) begin
      errors++;
      $display("FAIL proc_halt durum=%0d rst=%0b komut=%h", durum, islemci_reset, komut_islemci);
    end
    test_reset();
  endtask

  task automatic test_reset_mid_load();
    logic [31:0] w1[$] = '{32'hDEAD_BEEF};
    int cut[2] = '{6, 9};
    foreach (cut[c]) begin
      do_reset();
      send_byte(8'h03);
      send_byte(8'h00);
      repeat (cut[c] - 2) send_byte(8'($urandom));
      test_reset();
      load(1, w1, 0, 0);
      peek(32'h0); peek(32'h4);
    end
  endtask

  task automatic test_random();
    repeat (4) begin
      logic [31:0] w[$];
      int n = $urandom_range(24, 1);
      for (int i = 0; i < n; i++) w.push_back($urandom);
      do_reset();
      load(n, w, 0, 2);
      for (int a = 0; a < 4 * n + 8; a += $urandom_range(3, 1)) peek(32'(a));
      repeat (4) peek($urandom);
    end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_basic_load();
    test_gaps();
    test_bad_count();
    test_fetch_halt();
    test_hata_islemci();
    test_reset_mid_load();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
